// File: rtl/phy_rx_deframer.sv
// Receive-side PHY deframer: checks preamble/SFD on the 4-bit nibble stream,
// packs nibbles (low half first) into bytes and closes each frame with a
// {len,len} control word plus an error flag. Single clock domain (clk_phy).
// reset_n is asserted asynchronously; its release is expected to be
// synchronous to clk_phy (synchronised upstream).
module phy_rx_deframer #(
  parameter int unsigned MIN_PRE = 4,     // minimum 0x5 nibbles before SFD (<= 15)
  parameter int unsigned MIN_LEN = 64,    // shorter frames are runts
  parameter int unsigned MAX_LEN = 2047   // byte limit, <= 4095
) (
  input  logic        clk_phy,
  input  logic        reset_n,
  input  logic        phy_rx_dv,
  input  logic [3:0]  phy_data_in,
  output logic [7:0]  f_data_out,
  output logic        f_data_valid,
  output logic [23:0] f_ctrl_out,
  output logic        f_ctrl_valid,
  output logic        f_frame_err
);

  localparam logic [3:0]  PreNib = 4'h5;
  localparam logic [3:0]  SfdNib = 4'hD;
  localparam logic [3:0]  PreSat = 4'hF;
  localparam logic [3:0]  MinPre = 4'(MIN_PRE);
  localparam logic [11:0] MinLen = 12'(MIN_LEN);
  localparam logic [11:0] MaxLen = 12'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [11:0] len_q, len_d;
  logic        phase_q, phase_d;     // 1: low nibble held, waiting for high nibble
  logic [3:0]  low_q, low_d;
  logic        ovf_q, ovf_d;         // DROP was entered because of oversize

  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic [23:0] ctrl_q, ctrl_d;
  logic        ctrl_valid_q, ctrl_valid_d;
  logic        err_q, err_d;

  // Decode conditions shared by the FSM and the datapath.
  logic pre_nib, sfd_nib, pre_ok, len_full;
  always_comb begin
    pre_nib  = (phy_data_in == PreNib);
    sfd_nib  = (phy_data_in == SfdNib);
    pre_ok   = (pre_cnt_q >= MinPre);
    len_full = (len_q == MaxLen);
  end

  // Next-state logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (phy_rx_dv) begin
          state_d = pre_nib ? StPre : StDrop;
        end
      end
      StPre: begin
        if (!phy_rx_dv) begin
          state_d = StIdle;
        end else if (pre_nib) begin
          state_d = StPre;
        end else if (sfd_nib && pre_ok) begin
          state_d = StData;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!phy_rx_dv) begin
          state_d = StIdle;
        end else if (phase_q && len_full) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (!phy_rx_dv) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: counters, byte assembly and the output strobes.
  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    phase_d      = phase_q;
    low_d        = low_q;
    ovf_d        = ovf_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        ovf_d = 1'b0;
        if (phy_rx_dv && pre_nib) begin
          pre_cnt_d = 4'd1;
        end
      end
      StPre: begin
        if (phy_rx_dv) begin
          if (pre_nib) begin
            if (pre_cnt_q != PreSat) begin
              pre_cnt_d = pre_cnt_q + 4'd1;
            end
          end else if (sfd_nib && pre_ok) begin
            len_d   = 12'd0;
            phase_d = 1'b0;
          end else begin
            ovf_d = 1'b0;
          end
        end
      end
      StData: begin
        if (!phy_rx_dv) begin
          // Frame end; a dangling low nibble is dropped but flags the error.
          ctrl_valid_d = 1'b1;
          ctrl_d       = {len_q, len_q};
          err_d        = (len_q < MinLen) | phase_q;
          phase_d      = 1'b0;
        end else if (!phase_q) begin
          low_d   = phy_data_in;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (len_full) begin
            ovf_d = 1'b1;
          end else begin
            data_d       = {phy_data_in, low_q};
            data_valid_d = 1'b1;
            len_d        = len_q + 12'd1;
          end
        end
      end
      StDrop: begin
        if (!phy_rx_dv) begin
          ovf_d = 1'b0;
          if (ovf_q) begin
            ctrl_valid_d = 1'b1;
            ctrl_d       = {MaxLen, MaxLen};
            err_d        = 1'b1;
          end
        end
      end
      default: begin
        ovf_d = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q    <= 4'd0;
      len_q        <= 12'd0;
      phase_q      <= 1'b0;
      low_q        <= 4'd0;
      ovf_q        <= 1'b0;
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
      ctrl_q       <= 24'd0;
      ctrl_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
      ovf_q        <= ovf_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      err_q        <= err_d;
    end
  end

  assign f_data_out   = data_q;
  assign f_data_valid = data_valid_q;
  assign f_ctrl_out   = ctrl_q;
  assign f_ctrl_valid = ctrl_valid_q;
  assign f_frame_err  = err_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Directed bench for phy_rx_deframer. Instance A uses default parameters,
// instance B uses MAX_LEN=100; both see the same nibble stream.
module tb_phy_rx_deframer;

  logic        clk;
  logic        reset_n;
  logic        phy_rx_dv;
  logic [3:0]  phy_data_in;

  logic [7:0]  da, db;
  logic        dva, dvb;
  logic [23:0] ca, cb;
  logic        cva, cvb;
  logic        ea, eb;

  int checks;
  int errors;

  phy_rx_deframer u_dut_a (
    .clk_phy      (clk),
    .reset_n      (reset_n),
    .phy_rx_dv    (phy_rx_dv),
    .phy_data_in  (phy_data_in),
    .f_data_out   (da),
    .f_data_valid (dva),
    .f_ctrl_out   (ca),
    .f_ctrl_valid (cva),
    .f_frame_err  (ea)
  );

  phy_rx_deframer #(
    .MAX_LEN (100)
  ) u_dut_b (
    .clk_phy      (clk),
    .reset_n      (reset_n),
    .phy_rx_dv    (phy_rx_dv),
    .phy_data_in  (phy_data_in),
    .f_data_out   (db),
    .f_data_valid (dvb),
    .f_ctrl_out   (cb),
    .f_ctrl_valid (cvb),
    .f_frame_err  (eb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one nibble on the falling edge; return just after the sampling edge.
  task automatic step(input logic dv, input logic [3:0] nib);
    @(negedge clk);
    phy_rx_dv   = dv;
    phy_data_in = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic preamble(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 4'h5);
    step(1'b1, 4'hD);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_a, input logic exp_b);
    step(1'b1, b[3:0]);
    chk("lo_strobe_a", dva, 0);
    chk("lo_strobe_b", dvb, 0);
    step(1'b1, b[7:4]);
    chk("strobe_a", dva, exp_a);
    chk("strobe_b", dvb, exp_b);
    chk("ctrl_mid_a", cva, 0);
    chk("ctrl_mid_b", cvb, 0);
    if (exp_a) chk("byte_a", da, b);
    if (exp_b) chk("byte_b", db, b);
  endtask

  // A expects every byte; B stops delivering at its 100-byte limit.
  task automatic data_bytes(input int n, input logic inc);
    for (int i = 0; i < n; i++) send_byte(inc ? 8'(i) : 8'hF0, 1'b1, i < 100);
  endtask

  task automatic dropped_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i + 8'h31), 1'b0, 1'b0);
  endtask

  task automatic end_frame(input logic cv_a_e, input logic [23:0] c_a_e, input logic e_a_e,
                           input logic cv_b_e, input logic [23:0] c_b_e, input logic e_b_e);
    step(1'b0, 4'h0);
    chk("end_dv_a", dva, 0);
    chk("end_dv_b", dvb, 0);
    chk("ctrl_valid_a", cva, cv_a_e);
    chk("ctrl_valid_b", cvb, cv_b_e);
    if (cv_a_e) begin
      chk("ctrl_a", ca, c_a_e);
      chk("err_a", ea, e_a_e);
    end
    if (cv_b_e) begin
      chk("ctrl_b", cb, c_b_e);
      chk("err_b", eb, e_b_e);
    end
  endtask

  task automatic idle_chk(input logic [23:0] c_a_e, input logic [23:0] c_b_e);
    step(1'b0, 4'h0);
    chk("idle_cv_a", cva, 0);
    chk("idle_cv_b", cvb, 0);
    chk("idle_dv_a", dva, 0);
    chk("idle_hold_a", ca, c_a_e);
    chk("idle_hold_b", cb, c_b_e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_da"}, da, 0);
    chk({tag, "_dva"}, dva, 0);
    chk({tag, "_ca"}, ca, 0);
    chk({tag, "_cva"}, cva, 0);
    chk({tag, "_ea"}, ea, 0);
    chk({tag, "_db"}, db, 0);
    chk({tag, "_dvb"}, dvb, 0);
    chk({tag, "_cb"}, cb, 0);
    chk({tag, "_cvb"}, cvb, 0);
    chk({tag, "_eb"}, eb, 0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    phy_rx_dv   = 1'b0;
    phy_data_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 512 x 0xF0; B hits its limit at 100 bytes.
    preamble(15);
    data_bytes(512, 1'b0);
    end_frame(1'b1, 24'h200200, 1'b0, 1'b1, 24'h064064, 1'b1);
    idle_chk(24'h200200, 24'h064064);

    // 64 incrementing bytes, then back-to-back with a single dv=0 gap and
    // a preamble of exactly MIN_PRE nibbles.
    preamble(15);
    data_bytes(64, 1'b1);
    end_frame(1'b1, 24'h040040, 1'b0, 1'b1, 24'h040040, 1'b0);
    preamble(4);
    chk("b2b_cv_a", cva, 0);
    data_bytes(64, 1'b1);
    end_frame(1'b1, 24'h040040, 1'b0, 1'b1, 24'h040040, 1'b0);
    idle_chk(24'h040040, 24'h040040);

    // Runt frame.
    preamble(7);
    data_bytes(10, 1'b0);
    end_frame(1'b1, 24'h00A00A, 1'b1, 1'b1, 24'h00A00A, 1'b1);
    idle_chk(24'h00A00A, 24'h00A00A);

    // Runt with a dangling nibble: no 21st byte.
    preamble(7);
    data_bytes(20, 1'b1);
    step(1'b1, 4'h3);
    chk("dangle_dv_a", dva, 0);
    end_frame(1'b1, 24'h014014, 1'b1, 1'b1, 24'h014014, 1'b1);
    idle_chk(24'h014014, 24'h014014);

    // Full-size frame with a dangling nibble: error from odd nibble alone.
    preamble(7);
    data_bytes(64, 1'b1);
    step(1'b1, 4'h3);
    chk("dangle64_dv_a", dva, 0);
    end_frame(1'b1, 24'h040040, 1'b1, 1'b1, 24'h040040, 1'b1);
    idle_chk(24'h040040, 24'h040040);

    // Broken preamble 5,5,7.
    step(1'b1, 4'h5);
    step(1'b1, 4'h5);
    step(1'b1, 4'h7);
    step(1'b1, 4'hD);
    dropped_bytes(4);
    end_frame(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
    idle_chk(24'h040040, 24'h040040);

    // Preamble one short of MIN_PRE.
    preamble(3);
    dropped_bytes(4);
    end_frame(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
    idle_chk(24'h040040, 24'h040040);

    // Non-preamble first nibble: DROP must not restart on a later preamble.
    step(1'b1, 4'hD);
    preamble(6);
    dropped_bytes(4);
    end_frame(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
    idle_chk(24'h040040, 24'h040040);

    // 150 bytes: A delivers all, B stops at 100 and flags oversize.
    preamble(15);
    data_bytes(150, 1'b0);
    end_frame(1'b1, 24'h096096, 1'b0, 1'b1, 24'h064064, 1'b1);
    idle_chk(24'h096096, 24'h064064);

    // Zero-length frame.
    preamble(15);
    end_frame(1'b1, 24'h000000, 1'b1, 1'b1, 24'h000000, 1'b1);
    idle_chk(24'h000000, 24'h000000);

    // Reset mid-DATA with dv held high.
    preamble(15);
    data_bytes(5, 1'b1);
    chk("pre_rst_byte_a", da, 8'h04);
    @(negedge clk);
    phy_data_in = 4'h6;
    reset_n     = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step(1'b1, 4'h7);
    step(1'b1, 4'h8);
    chk_all_zero("rst_hold");
    @(negedge clk);
    reset_n     = 1'b1;
    phy_rx_dv   = 1'b1;
    phy_data_in = 4'hA;
    @(posedge clk);
    #1;
    chk("rel_dv_a", dva, 0);
    preamble(4);
    dropped_bytes(3);
    end_frame(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0);
    idle_chk(24'h000000, 24'h000000);

    // Next good frame after the reset.
    preamble(15);
    data_bytes(64, 1'b1);
    end_frame(1'b1, 24'h040040, 1'b0, 1'b1, 24'h040040, 1'b0);
    idle_chk(24'h040040, 24'h040040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
